// File: rtl/ramb_pkg.sv
// Shared constants and elaboration helpers for the asymmetric dual-port RAM.
// Write-mode codes, log2 and per-port address width.
package ramb_pkg;

  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;
  localparam int WM_NO_CHANGE   = 2;
  localparam int WM_ILLEGAL     = 3;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // A single-word port still needs a 1-bit address bus.
  function automatic int addr_w(input int mem_bits, input int width);
    int w;
    w = clog2(mem_bits / width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ramb_out_stage.sv
// Per-port read path: output latch with write-mode select and sync reset,
// plus the optional pipeline register.
module ramb_out_stage
  import ramb_pkg::*;
#(
  parameter int               WIDTH      = 2,
  parameter int               WRITE_MODE = WM_WRITE_FIRST,
  parameter int               DO_REG     = 0,
  parameter logic [WIDTH-1:0] SRVAL      = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic             srst,
  input  logic             regce,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] lat;
  logic [WIDTH-1:0] lat_nxt;

  // rdata is the pre-edge word, which also covers read-first and
  // a reader losing a collision.
  always_comb begin
    lat_nxt = lat;
    if (srst) begin
      lat_nxt = SRVAL;
    end else if (!we) begin
      lat_nxt = rdata;
    end else if (WRITE_MODE == WM_WRITE_FIRST) begin
      lat_nxt = wdata;
    end else if (WRITE_MODE == WM_READ_FIRST) begin
      lat_nxt = rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat <= SRVAL;
    end else if (en) begin
      lat <= lat_nxt;
    end
  end

  generate
    if (DO_REG != 0) begin : g_pipe
      logic [WIDTH-1:0] pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe <= SRVAL;
        end else if (regce) begin
          pipe <= srst ? SRVAL : lat;
        end
      end

      assign dout = pipe;
    end else begin : g_direct
      logic unused_regce;
      assign unused_regce = regce;
      assign dout = lat;
    end
  endgenerate

endmodule

// File: rtl/ramb_asym_dp_sc.sv
// Single-clock true dual-port RAM with independent port widths over one
// shared bit array; B wins overlapping bits when both ports write.
module ramb_asym_dp_sc
  import ramb_pkg::*;
#(
  parameter int                    MEM_BITS     = 4096,
  parameter int                    WIDTH_A      = 2,
  parameter int                    WIDTH_B      = 8,
  parameter string                 WRITE_MODE_A = "WRITE_FIRST",
  parameter string                 WRITE_MODE_B = "WRITE_FIRST",
  parameter int                    DO_REG       = 0,
  parameter logic [WIDTH_A-1:0]    SRVAL_A      = '0,
  parameter logic [WIDTH_B-1:0]    SRVAL_B      = '0,
  parameter logic [MEM_BITS-1:0]   INIT         = '0
) (
  input  logic                                 CLK,
  input  logic                                 RSTN,
  input  logic                                 ENA,
  input  logic                                 WEA,
  input  logic                                 RSTA,
  input  logic                                 REGCEA,
  input  logic [addr_w(MEM_BITS,WIDTH_A)-1:0]  ADDRA,
  input  logic [WIDTH_A-1:0]                   DIA,
  output logic [WIDTH_A-1:0]                   DOA,
  input  logic                                 ENB,
  input  logic                                 WEB,
  input  logic                                 RSTB,
  input  logic                                 REGCEB,
  input  logic [addr_w(MEM_BITS,WIDTH_B)-1:0]  ADDRB,
  input  logic [WIDTH_B-1:0]                   DIB,
  output logic [WIDTH_B-1:0]                   DOB,
  output logic                                 COLL
);

  localparam int MODE_A =
    (WRITE_MODE_A == "WRITE_FIRST") ? WM_WRITE_FIRST :
    (WRITE_MODE_A == "READ_FIRST")  ? WM_READ_FIRST  :
    (WRITE_MODE_A == "NO_CHANGE")   ? WM_NO_CHANGE   :
                                      WM_ILLEGAL;
  localparam int MODE_B =
    (WRITE_MODE_B == "WRITE_FIRST") ? WM_WRITE_FIRST :
    (WRITE_MODE_B == "READ_FIRST")  ? WM_READ_FIRST  :
    (WRITE_MODE_B == "NO_CHANGE")   ? WM_NO_CHANGE   :
                                      WM_ILLEGAL;

  localparam int IW  = (clog2(MEM_BITS) < 1) ? 1 : clog2(MEM_BITS);
  localparam int LWA = clog2(WIDTH_A);
  localparam int LWB = clog2(WIDTH_B);

  generate
    if (!is_pow2(MEM_BITS)) begin : g_bad_mem
      $error("ramb_asym_dp_sc: MEM_BITS must be a power of two");
    end
    if (!is_pow2(WIDTH_A) || WIDTH_A > MEM_BITS) begin : g_bad_wa
      $error("ramb_asym_dp_sc: WIDTH_A must be a power of two <= MEM_BITS");
    end
    if (!is_pow2(WIDTH_B) || WIDTH_B > MEM_BITS) begin : g_bad_wb
      $error("ramb_asym_dp_sc: WIDTH_B must be a power of two <= MEM_BITS");
    end
    if (MODE_A == WM_ILLEGAL) begin : g_bad_ma
      $error("ramb_asym_dp_sc: unknown WRITE_MODE_A");
    end
    if (MODE_B == WM_ILLEGAL) begin : g_bad_mb
      $error("ramb_asym_dp_sc: unknown WRITE_MODE_B");
    end
    if (DO_REG != 0 && DO_REG != 1) begin : g_bad_reg
      $error("ramb_asym_dp_sc: DO_REG must be 0 or 1");
    end
  endgenerate

  logic [MEM_BITS-1:0] mem = INIT;

  logic [IW-1:0]       idx_a;
  logic [IW-1:0]       idx_b;
  logic [IW:0]         end_a;
  logic [IW:0]         end_b;
  logic                overlap;
  logic                we_a;
  logic                we_b;
  logic                coll_nxt;
  logic [MEM_BITS-1:0] msk_a;
  logic [MEM_BITS-1:0] msk_b;
  logic [MEM_BITS-1:0] dat_a;
  logic [MEM_BITS-1:0] dat_b;
  logic [MEM_BITS-1:0] mem_nxt;
  logic [WIDTH_A-1:0]  rd_a;
  logic [WIDTH_B-1:0]  rd_b;

  assign idx_a = IW'(ADDRA) << LWA;
  assign idx_b = IW'(ADDRB) << LWB;

  // End indices are exclusive, one bit wider to hold MEM_BITS itself.
  assign end_a = {1'b0, idx_a} + (IW+1)'(WIDTH_A);
  assign end_b = {1'b0, idx_b} + (IW+1)'(WIDTH_B);

  assign overlap = ({1'b0, idx_a} < end_b) && ({1'b0, idx_b} < end_a);

  assign we_a = ENA & WEA;
  assign we_b = ENB & WEB;

  assign coll_nxt = ENA & ENB & (WEA | WEB) & overlap;

  assign msk_a = we_a ? (MEM_BITS'({WIDTH_A{1'b1}}) << idx_a) : '0;
  assign msk_b = we_b ? (MEM_BITS'({WIDTH_B{1'b1}}) << idx_b) : '0;
  assign dat_a = MEM_BITS'(DIA) << idx_a;
  assign dat_b = MEM_BITS'(DIB) << idx_b;

  // B's mask removes A's claim on shared bits.
  assign mem_nxt = (mem & ~(msk_a | msk_b))
                 | (dat_a & msk_a & ~msk_b)
                 | (dat_b & msk_b);

  always_ff @(posedge CLK) begin
    mem <= mem_nxt;
  end

  assign rd_a = mem[idx_a +: WIDTH_A];
  assign rd_b = mem[idx_b +: WIDTH_B];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      COLL <= 1'b0;
    end else begin
      COLL <= coll_nxt;
    end
  end

  ramb_out_stage #(
    .WIDTH      (WIDTH_A),
    .WRITE_MODE (MODE_A),
    .DO_REG     (DO_REG),
    .SRVAL      (SRVAL_A)
  ) u_out_a (
    .clk   (CLK),
    .rst_n (RSTN),
    .en    (ENA),
    .we    (WEA),
    .srst  (RSTA),
    .regce (REGCEA),
    .wdata (DIA),
    .rdata (rd_a),
    .dout  (DOA)
  );

  ramb_out_stage #(
    .WIDTH      (WIDTH_B),
    .WRITE_MODE (MODE_B),
    .DO_REG     (DO_REG),
    .SRVAL      (SRVAL_B)
  ) u_out_b (
    .clk   (CLK),
    .rst_n (RSTN),
    .en    (ENB),
    .we    (WEB),
    .srst  (RSTB),
    .regce (REGCEB),
    .wdata (DIB),
    .rdata (rd_b),
    .dout  (DOB)
  );

endmodule

// File: tb/tb_ramb_asym_dp_sc.sv
// Directed bench for ramb_asym_dp_sc: four configurations share one
// stimulus stream; expectations queue up with their due cycle.
module tb_ramb_asym_dp_sc;

  logic        CLK;
  logic        RSTN;
  logic        ENA, WEA, RSTA, REGCEA;
  logic [10:0] ADDRA;
  logic [1:0]  DIA;
  logic        ENB, WEB, RSTB, REGCEB;
  logic [8:0]  ADDRB;
  logic [7:0]  DIB;

  logic [1:0] doa_wf, doa_rf, doa_nc, doa_rg;
  logic [7:0] dob_wf, dob_rf, dob_nc, dob_rg;
  logic       coll_wf, coll_rf, coll_nc, coll_rg;

  localparam int S_WF_A = 0;
  localparam int S_WF_B = 1;
  localparam int S_COLL = 2;
  localparam int S_RF_A = 3;
  localparam int S_NC_A = 4;
  localparam int S_RG_A = 5;
  localparam int S_RG_B = 6;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   ntot  = 0;
  int   npass = 0;
  int   nfail = 0;

  ramb_asym_dp_sc #(
    .WRITE_MODE_A ("WRITE_FIRST"), .SRVAL_A (2'b10), .SRVAL_B (8'h3C)
  ) u_wf (
    .CLK (CLK), .RSTN (RSTN),
    .ENA (ENA), .WEA (WEA), .RSTA (RSTA), .REGCEA (REGCEA),
    .ADDRA (ADDRA), .DIA (DIA), .DOA (doa_wf),
    .ENB (ENB), .WEB (WEB), .RSTB (RSTB), .REGCEB (REGCEB),
    .ADDRB (ADDRB), .DIB (DIB), .DOB (dob_wf), .COLL (coll_wf)
  );

  ramb_asym_dp_sc #(
    .WRITE_MODE_A ("READ_FIRST"), .SRVAL_A (2'b10)
  ) u_rf (
    .CLK (CLK), .RSTN (RSTN),
    .ENA (ENA), .WEA (WEA), .RSTA (RSTA), .REGCEA (REGCEA),
    .ADDRA (ADDRA), .DIA (DIA), .DOA (doa_rf),
    .ENB (ENB), .WEB (WEB), .RSTB (RSTB), .REGCEB (REGCEB),
    .ADDRB (ADDRB), .DIB (DIB), .DOB (dob_rf), .COLL (coll_rf)
  );

  ramb_asym_dp_sc #(
    .WRITE_MODE_A ("NO_CHANGE"), .SRVAL_A (2'b10)
  ) u_nc (
    .CLK (CLK), .RSTN (RSTN),
    .ENA (ENA), .WEA (WEA), .RSTA (RSTA), .REGCEA (REGCEA),
    .ADDRA (ADDRA), .DIA (DIA), .DOA (doa_nc),
    .ENB (ENB), .WEB (WEB), .RSTB (RSTB), .REGCEB (REGCEB),
    .ADDRB (ADDRB), .DIB (DIB), .DOB (dob_nc), .COLL (coll_nc)
  );

  ramb_asym_dp_sc #(
    .DO_REG (1), .SRVAL_A (2'b10), .SRVAL_B (8'h5A)
  ) u_rg (
    .CLK (CLK), .RSTN (RSTN),
    .ENA (ENA), .WEA (WEA), .RSTA (RSTA), .REGCEA (REGCEA),
    .ADDRA (ADDRA), .DIA (DIA), .DOA (doa_rg),
    .ENB (ENB), .WEB (WEB), .RSTB (RSTB), .REGCEB (REGCEB),
    .ADDRB (ADDRB), .DIB (DIB), .DOB (dob_rg), .COLL (coll_rg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] obs(input int sel);
    logic [7:0] r;
    r = 8'hxx;
    case (sel)
      S_WF_A: r = {6'd0, doa_wf};
      S_WF_B: r = dob_wf;
      S_COLL: r = {7'd0, coll_wf};
      S_RF_A: r = {6'd0, doa_rf};
      S_NC_A: r = {6'd0, doa_nc};
      S_RG_A: r = {6'd0, doa_rg};
      S_RG_B: r = dob_rg;
      default: r = 8'hxx;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] o,
                       input logic [7:0] e);
    ntot++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic expect_at(input int lat, input int sel,
                           input logic [7:0] v, input string tag);
    exp_t x;
    x.due = cyc + lat;
    x.sel = sel;
    x.val = v;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, obs(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  task automatic idle();
    ENA = 0; WEA = 0; RSTA = 0; REGCEA = 1; ADDRA = '0; DIA = '0;
    ENB = 0; WEB = 0; RSTB = 0; REGCEB = 1; ADDRB = '0; DIB = '0;
  endtask

  task automatic pa(input bit en, input bit we, input int addr,
                    input logic [1:0] d);
    ENA = en; WEA = we; ADDRA = 11'(addr); DIA = d;
  endtask

  task automatic pb(input bit en, input bit we, input int addr,
                    input logic [7:0] d);
    ENB = en; WEB = we; ADDRB = 9'(addr); DIB = d;
  endtask

  initial begin
    logic [1:0] mv [4];
    mv = '{2'b01, 2'b01, 2'b10, 2'b10};
    idle();
    RSTN = 1'b1;
    #1 RSTN = 1'b0;
    #2;
    check("rst_doa", obs(S_WF_A), 8'h02);
    check("rst_dob", obs(S_WF_B), 8'h3C);
    check("rst_coll", obs(S_COLL), 8'h00);
    check("rst_pipe_b", obs(S_RG_B), 8'h5A);
    #8 RSTN = 1'b1;

    // asymmetric mapping
    idle(); pb(1, 1, 3, 8'hA5);
    expect_at(1, S_WF_B, 8'hA5, "wr_b3_wf");
    tick();
    for (int i = 0; i < 4; i++) begin
      idle(); pa(1, 0, 12 + i, 2'b00);
      expect_at(1, S_WF_A, {6'd0, mv[i]}, "map_wf");
      expect_at(1, S_RF_A, {6'd0, mv[i]}, "map_rf");
      expect_at(1, S_NC_A, {6'd0, mv[i]}, "map_nc");
      expect_at(2, S_RG_A, {6'd0, mv[i]}, "map_pipe");
      tick();
    end

    // output pipeline
    idle(); pb(1, 0, 4, 8'h00);
    expect_at(1, S_WF_B, 8'h00, "rd_b4");
    tick();
    idle(); pb(1, 0, 3, 8'h00);
    expect_at(1, S_RG_B, 8'h00, "pipe_prev");
    expect_at(2, S_RG_B, 8'hA5, "pipe_lat2");
    tick();
    idle(); tick();
    idle(); pb(1, 0, 4, 8'h00); tick();
    idle(); REGCEB = 0;
    expect_at(1, S_RG_B, 8'hA5, "regce_hold");
    tick();
    idle(); RSTB = 1;
    expect_at(1, S_RG_B, 8'h5A, "pipe_srst");
    expect_at(1, S_WF_B, 8'h00, "dis_hold");
    tick();
    idle();
    expect_at(1, S_RG_B, 8'h00, "pipe_reload");
    tick();
    idle(); RSTB = 1; pb(1, 1, 5, 8'hC3);
    expect_at(1, S_WF_B, 8'h3C, "latch_srst");
    tick();
    idle(); pb(1, 0, 5, 8'h00);
    expect_at(1, S_WF_B, 8'hC3, "srst_wr_done");
    tick();

    // write modes
    idle(); pa(1, 1, 12, 2'b11);
    expect_at(1, S_WF_A, 8'h03, "wm_wf");
    expect_at(1, S_RF_A, 8'h01, "wm_rf");
    expect_at(1, S_NC_A, 8'h02, "wm_nc");
    tick();
    idle(); pa(1, 0, 12, 2'b00);
    expect_at(1, S_WF_A, 8'h03, "reread_wf");
    expect_at(1, S_RF_A, 8'h03, "reread_rf");
    expect_at(1, S_NC_A, 8'h03, "reread_nc");
    tick();

    // write-write collision
    idle(); pa(1, 1, 12, 2'b11); pb(1, 1, 3, 8'h00);
    expect_at(1, S_COLL, 8'h01, "ww_coll");
    expect_at(1, S_WF_B, 8'h00, "ww_dob");
    tick();
    idle(); pa(1, 0, 12, 2'b00); pb(1, 1, 4, 8'h11);
    expect_at(1, S_COLL, 8'h00, "no_overlap");
    expect_at(1, S_WF_A, 8'h00, "b_wins");
    tick();
    idle(); pb(1, 0, 3, 8'h00);
    expect_at(1, S_WF_B, 8'h00, "b3_zero");
    tick();

    // read-write collision
    idle(); pb(1, 1, 3, 8'h04); tick();
    idle(); pa(1, 0, 13, 2'b00); pb(1, 1, 3, 8'hFF);
    expect_at(1, S_WF_A, 8'h01, "rw_old_wf");
    expect_at(1, S_RF_A, 8'h01, "rw_old_rf");
    expect_at(1, S_NC_A, 8'h01, "rw_old_nc");
    expect_at(1, S_COLL, 8'h01, "rw_coll");
    expect_at(1, S_WF_B, 8'hFF, "rw_dob");
    tick();
    idle(); pa(1, 0, 13, 2'b00);
    expect_at(1, S_WF_A, 8'h03, "rw_new");
    expect_at(1, S_COLL, 8'h00, "coll_clear");
    tick();

    // reset mid-cycle
    idle(); pa(1, 1, 12, 2'b01); pb(1, 0, 3, 8'h00);
    expect_at(1, S_COLL, 8'h01, "wr_rd_coll");
    expect_at(1, S_WF_B, 8'hFF, "wr_rd_old");
    tick();
    #3 RSTN = 1'b0;
    #1;
    check("async_doa", obs(S_WF_A), 8'h02);
    check("async_coll", obs(S_COLL), 8'h00);
    check("async_dob", obs(S_WF_B), 8'h3C);
    check("async_pipe_b", obs(S_RG_B), 8'h5A);
    check("async_pipe_a", obs(S_RG_A), 8'h02);
    #2 RSTN = 1'b1;
    idle(); pa(1, 0, 12, 2'b00); pb(1, 0, 3, 8'h00);
    expect_at(1, S_WF_A, 8'h01, "keep_a12");
    expect_at(1, S_WF_B, 8'hFD, "keep_b3");
    expect_at(1, S_COLL, 8'h00, "rd_rd_nocoll");
    tick();
    idle(); RSTA = 1; pa(1, 0, 12, 2'b00); pb(1, 0, 4, 8'h00);
    expect_at(1, S_WF_A, 8'h02, "rsta_latch");
    expect_at(1, S_RG_A, 8'h02, "rsta_pipe");
    expect_at(1, S_WF_B, 8'h11, "keep_b4");
    tick();
    idle(); pb(1, 0, 5, 8'h00);
    expect_at(1, S_WF_B, 8'hC3, "keep_b5");
    tick();
    idle(); tick();

    check("sb_drained", 8'(sb.size()), 8'h00);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
